// File: rtl/timer_pkg.sv
// Shared constants for the oven timer front end: FSM state encoding and BCD limits.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [3:0] BCD_MAX          = 4'd9;
  localparam int         MAX_TENS_DEFAULT = 5;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Three-digit BCD keypad buffer (min, tens-of-seconds, seconds) with microwave-style
// shift-in, synchronous clear and tens-digit legality check.
module bcd_entry_reg
  import timer_pkg::*;
#(
  parameter int MAX_TENS = MAX_TENS_DEFAULT
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       shift_i,
  input  logic       clear_i,
  input  logic [3:0] digit_i,
  output logic [3:0] min_o,
  output logic [3:0] st_o,
  output logic [3:0] so_o,
  output logic       nonzero_o,
  output logic       key_err_o
);

  logic [3:0] min_q, st_q, so_q;
  logic       err_q;
  logic       reject;

  // The seconds digit becomes the tens digit on a shift, so it must already be a legal tens value.
  assign reject = shift_i && (so_q > 4'(MAX_TENS));

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      min_q <= '0;
      st_q  <= '0;
      so_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject && !clear_i;
      if (clear_i) begin
        min_q <= '0;
        st_q  <= '0;
        so_q  <= '0;
      end else if (shift_i && !reject) begin
        min_q <= st_q;
        st_q  <= so_q;
        so_q  <= digit_i;
      end
    end
  end

  assign min_o     = min_q;
  assign st_o      = st_q;
  assign so_o      = so_q;
  assign nonzero_o = |{min_q, st_q, so_q};
  assign key_err_o = err_q;

endmodule

// File: rtl/timer_entrada.sv
// Keypad-to-timer front end: digit entry, load/run/pause sequencing and done hold.
// Optional DOOR_INTERLOCK_EN adds door_open, which pauses RUN and blocks start.
//
//   state | meaning
//   IDLE  | buffer empty, waiting for digits
//   ENTRY | digits being keyed in
//   LOAD  | one-cycle load strobe to the timer
//   RUN   | timer counting, watching zero
//   PAUSE | counting halted, buffer kept
//   DONE  | done held for DONE_CYCLES cycles
module timer_entrada
  import timer_pkg::*;
#(
  parameter int DONE_CYCLES = 8,
  parameter int MAX_TENS    = MAX_TENS_DEFAULT
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       zero,
`ifdef DOOR_INTERLOCK_EN
  input  logic       door_open,
`endif
  output logic [3:0] data_min,
  output logic [3:0] data_st,
  output logic [3:0] data_so,
  output logic       load,
  output logic       enable,
  output logic       done,
  output logic       key_err
);

  localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_q, enable_q, done_q;
  logic            shift, clear, nonzero;
  logic            door, start_ok;

`ifdef DOOR_INTERLOCK_EN
  assign door = door_open;
`else
  assign door = 1'b0;
`endif

  assign start_ok = start && !door;

  bcd_entry_reg #(.MAX_TENS(MAX_TENS)) u_entry (
    .clk       (clk),
    .clearn    (clearn),
    .shift_i   (shift),
    .clear_i   (clear),
    .digit_i   (key_code),
    .min_o     (data_min),
    .st_o      (data_st),
    .so_o      (data_so),
    .nonzero_o (nonzero),
    .key_err_o (key_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (stop) begin
          if (state_q == ST_ENTRY) begin
            clear   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (start_ok) begin
          // A start always swallows a simultaneous digit, even when the buffer is empty.
          if (nonzero) state_d = ST_LOAD;
        end else if (key_valid && is_digit(key_code)) begin
          shift   = 1'b1;
          state_d = ST_ENTRY;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (zero) begin
          state_d = ST_DONE;
          cnt_d   = CW'(DONE_CYCLES - 1);
        end else if (stop || door) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else if (start_ok) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop || cnt_q == '0) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_q   <= (state_d == ST_LOAD);
      enable_q <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign load   = load_q;
  assign enable = enable_q;
  assign done   = done_q;

endmodule

// File: tb/tb_timer_entrada.sv
// Scoreboarded bench for timer_entrada: directed scenarios plus random keypad/start/stop/zero
// traffic predicted by a digit-queue reference model.
module tb_timer_entrada;

  localparam int DONE_CYCLES = 8;
  localparam int MAX_TENS    = 5;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       zero = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] data_min, data_st, data_so;
  logic       load, enable, done, key_err;

  always #5 clk = ~clk;

  timer_entrada #(.DONE_CYCLES(DONE_CYCLES), .MAX_TENS(MAX_TENS)) dut (
    .clk       (clk),
    .clearn    (clearn),
    .key_code  (key_code),
    .key_valid (key_valid),
    .start     (start),
    .stop      (stop),
    .zero      (zero),
`ifdef DOOR_INTERLOCK_EN
    .door_open (door_open),
`endif
    .data_min  (data_min),
    .data_st   (data_st),
    .data_so   (data_so),
    .load      (load),
    .enable    (enable),
    .done      (done),
    .key_err   (key_err)
  );

  typedef struct {
    int min;
    int st;
    int so;
    bit load;
    bit enable;
    bit done;
    bit key_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   out_idx = 0;

  // Reference model: entry held as a queue of three digits, oldest (minutes) first.
  typedef enum {M_IDLE, M_ENTRY, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_e;
  mode_e mode;
  int    dig[$];
  int    done_left;
  bit    m_err;

  function automatic int buf_value();
    return dig[0] * 100 + dig[1] * 10 + dig[2];
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    dig = '{0, 0, 0};
    done_left = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit st, input bit sp, input bit z);
    m_err = 1'b0;
    case (mode)
      M_IDLE, M_ENTRY: begin
        if (sp) begin
          if (mode == M_ENTRY) begin
            dig = '{0, 0, 0};
            mode = M_IDLE;
          end
        end else if (st) begin
          if (buf_value() != 0) mode = M_LOAD;
        end else if (kv && kc <= 9) begin
          if (dig[2] > MAX_TENS) m_err = 1'b1;
          else begin
            dig.delete(0);
            dig.push_back(kc);
            mode = M_ENTRY;
          end
        end
      end
      M_LOAD: mode = M_RUN;
      M_RUN: begin
        if (z) begin
          mode = M_DONE;
          done_left = DONE_CYCLES;
        end else if (sp) mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (sp) begin
          dig = '{0, 0, 0};
          mode = M_IDLE;
        end else if (st) mode = M_RUN;
      end
      M_DONE: begin
        done_left--;
        if (sp || done_left == 0) begin
          dig = '{0, 0, 0};
          mode = M_IDLE;
        end
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic step(input bit kv, input int kc, input bit st, input bit sp, input bit z);
    exp_t e;
    @(negedge clk);
    key_valid = kv;
    key_code  = 4'(kc);
    start     = st;
    stop      = sp;
    zero      = z;
    model_step(kv, kc, st, sp, z);
    e.min = dig[0];
    e.st = dig[1];
    e.so = dig[2];
    e.load = (mode == M_LOAD);
    e.enable = (mode == M_RUN);
    e.done = (mode == M_DONE);
    e.key_err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic key(input int k);
    step(1, k, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({data_min, data_st, data_so, load, enable, done, key_err} !== 16'h0) begin
      failures++;
      $display("FAIL %s got min=%0d st=%0d so=%0d load=%0b en=%0b done=%0b err=%0b, required all zero",
               name, data_min, data_st, data_so, load, enable, done, key_err);
    end
  endtask

  // Monitor: one registered output snapshot per issued stimulus cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        out_idx++;
        if (data_min !== 4'(e.min) || data_st !== 4'(e.st) || data_so !== 4'(e.so) ||
            load !== e.load || enable !== e.enable || done !== e.done || key_err !== e.key_err) begin
          failures++;
          $display("FAIL out[%0d] got min=%0d st=%0d so=%0d load=%0b en=%0b done=%0b err=%0b required min=%0d st=%0d so=%0d load=%0b en=%0b done=%0b err=%0b",
                   out_idx, data_min, data_st, data_so, load, enable, done, key_err,
                   e.min, e.st, e.so, e.load, e.enable, e.done, e.key_err);
        end
      end
    end
  end

  initial begin
    bit kv, st, sp, z;
    int kc;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    clearn = 1'b1;

    // Keys 1,3,0 then start: load pulse, then enable.
    key(1); key(3); key(0);
    step(0, 0, 1, 0, 0);
    idle(3);
    // Pause and resume without a reload.
    step(0, 0, 0, 1, 0);
    idle(2);
    step(0, 0, 1, 0, 0);
    idle(2);
    // Zero ends the run: done held DONE_CYCLES cycles, then cleared buffer.
    step(0, 0, 0, 0, 1);
    idle(DONE_CYCLES + 3);
    // Illegal tens digit rejected.
    key(1); key(7); key(5);
    idle(2);
    key(12);
    step(0, 0, 0, 1, 0);
    idle(1);
    // Start on an empty buffer is ignored; start+stop in RUN pauses.
    step(0, 0, 1, 0, 0);
    idle(1);
    key(2);
    step(1, 4, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 1, 0);
    idle(1);
    // Zero and stop together in RUN: DONE wins; stop in DONE ends early.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    idle(2);
    step(0, 0, 0, 1, 0);
    idle(2);
    // Zero during LOAD is ignored.
    key(9);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 99) < 35);
      kc = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
      st = ($urandom_range(0, 99) < 12);
      sp = ($urandom_range(0, 99) < 5);
      z  = ($urandom_range(0, 99) < 6);
      step(kv, kc, st, sp, z);
    end

    // Asynchronous reset in the middle of a run.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    key(4); key(2);
    step(0, 0, 1, 0, 0);
    idle(3);
    @(negedge clk);
    key_valid = 1'b0; start = 1'b0; stop = 1'b0; zero = 1'b0;
    #2 clearn = 1'b0;
    #1 check_all_zero("async_reset_mid_run");
    model_reset();
    @(negedge clk);
    check_all_zero("reset_held");
    clearn = 1'b1;
    key(3);
    step(0, 0, 1, 0, 0);
    idle(3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
